// File: rtl/fft_cfg_pkg.sv
// Shared configuration for the FFT input path.
// Holds the capture sequencer state encoding and a frame-length helper.
package fft_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAPT = 2'd1,
    GAP  = 2'd2,
    HALT = 2'd3
  } state_t;

  // Frame length in samples for a given log2 size.
  function automatic int unsigned frame_len(input int unsigned nall);
    return 32'd1 << nall;
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo counter with programmable wrap value.
// Ports:
//   areset  async active-low reset
//   clk     clock
//   clr     synchronous clear to 0 (wins over en)
//   en      advance by one
//   wrap    last value before the counter returns to 0
//   count   current value
//   tc      high while count equals wrap
module mod_counter #(
  parameter int W = 4
) (
  input  logic         areset,
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] wrap,
  output logic [W-1:0] count,
  output logic         tc
);

  assign tc = (count == wrap);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset)  count <= '0;
    else if (clr) count <= '0;
    else if (en)  count <= tc ? '0 : count + 1'b1;
  end

endmodule

// File: rtl/ad_frame_ctrl.sv
// ADC-side capture sequencer: selects which ADC samples are written into the
// input CDC FIFO, always in whole frames of 2^NALL samples.
// Ports:
//   areset, clk_ad      async active-low reset, ADC clock
//   start, stop         one-cycle capture / stop requests
//   mode_cont           1 = continuous frames, 0 = single frame (latched on start)
//   decim               keep 1 of every decim+1 valid samples (latched on start)
//   gap                 accepted slots skipped between frames (latched on start)
//   adc_valid, adc_data ADC sample stream
//   fifo_full           FIFO full flag, write-clock domain
//   en_ad, din_ad       FIFO write strobe and data, one clock after acceptance
//   frame_start/done    pulses on first / last write of a frame
//   busy                high in CAPT or GAP
//   ovf_err             sticky overflow flag
//   frame_cnt           frames completed since the last start
module ad_frame_ctrl
  import fft_cfg_pkg::*;
#(
  parameter int width = 16,
  parameter int NALL  = 9,
  parameter int DW    = 4,
  parameter int GW    = 8,
  parameter int FCW   = 16
) (
  input  logic             areset,
  input  logic             clk_ad,
  input  logic             start,
  input  logic             stop,
  input  logic             mode_cont,
  input  logic [DW-1:0]    decim,
  input  logic [GW-1:0]    gap,
  input  logic             adc_valid,
  input  logic [width-1:0] adc_data,
  input  logic             fifo_full,
  output logic             en_ad,
  output logic [width-1:0] din_ad,
  output logic             frame_start,
  output logic             frame_done,
  output logic             busy,
  output logic             ovf_err,
  output logic [FCW-1:0]   frame_cnt
);

  localparam int unsigned     FRAME_LEN   = frame_len(NALL);
  localparam logic [NALL-1:0] LAST_SAMPLE = NALL'(FRAME_LEN - 1);

  state_t state, state_nx;

  logic [DW-1:0]   decim_q;
  logic [GW-1:0]   gap_q;
  logic            cont_q;
  logic            stop_pend;

  logic [DW-1:0]   dcnt;
  logic            d_tc;
  logic [NALL-1:0] scnt;
  logic            s_tc;
  logic [GW-1:0]   gcnt;
  logic            g_tc;

  logic            active;     // CAPT or GAP
  logic            slot;       // accepted slot after decimation
  logic            go;         // capture (re)start
  logic            wr;         // issue a FIFO write next cycle
  logic            ovf_set;
  logic            frame_end;
  logic            gap_slot;

  assign active = (state == CAPT) || (state == GAP);
  assign busy   = active;
  assign slot   = adc_valid && (dcnt == '0);

  // Decimation phase runs through CAPT and GAP so gap slots use the same
  // sample grid as the frame writes.
  mod_counter #(.W(DW)) u_decim_cnt (
    .areset (areset),
    .clk    (clk_ad),
    .clr    (go),
    .en     (adc_valid && active),
    .wrap   (decim_q),
    .count  (dcnt),
    .tc     (d_tc)
  );

  mod_counter #(.W(NALL)) u_sample_cnt (
    .areset (areset),
    .clk    (clk_ad),
    .clr    (go),
    .en     (wr),
    .wrap   (LAST_SAMPLE),
    .count  (scnt),
    .tc     (s_tc)
  );

  // Held at 0 outside GAP so every gap starts from a fresh count.
  mod_counter #(.W(GW)) u_gap_cnt (
    .areset (areset),
    .clk    (clk_ad),
    .clr    (state != GAP),
    .en     (gap_slot),
    .wrap   (gap_q - 1'b1),
    .count  (gcnt),
    .tc     (g_tc)
  );

  // Counter outputs this block has no use for.
  logic unused_cnt;
  assign unused_cnt = ^{d_tc, gcnt};

  always_ff @(posedge clk_ad or negedge areset) begin
    if (!areset) state <= IDLE;
    else         state <= state_nx;
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nx  = state;
    go        = 1'b0;
    wr        = 1'b0;
    ovf_set   = 1'b0;
    frame_end = 1'b0;
    gap_slot  = 1'b0;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          go       = 1'b1;
          state_nx = CAPT;
        end
      end
      CAPT: begin
        if (slot) begin
          // Full is judged in the accepting cycle; the registered write that
          // would follow is dropped and the whole capture halts.
          if (fifo_full) begin
            ovf_set  = 1'b1;
            state_nx = HALT;
          end else begin
            wr = 1'b1;
            if (s_tc) begin
              frame_end = 1'b1;
              if (!cont_q || stop_pend || stop) state_nx = IDLE;
              else if (gap_q != '0)             state_nx = GAP;
              else                              state_nx = CAPT;
            end
          end
        end
      end
      GAP: begin
        if (stop) begin
          state_nx = IDLE;
        end else if (slot) begin
          gap_slot = 1'b1;
          if (g_tc) state_nx = CAPT;
        end
      end
      HALT: begin
        if (stop) begin
          state_nx = IDLE;
        end else if (start) begin
          go       = 1'b1;
          state_nx = CAPT;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_ad or negedge areset) begin
    if (!areset) begin
      decim_q     <= '0;
      gap_q       <= '0;
      cont_q      <= 1'b0;
      stop_pend   <= 1'b0;
      en_ad       <= 1'b0;
      din_ad      <= '0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      ovf_err     <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      if (go) begin
        decim_q <= decim;
        gap_q   <= gap;
        cont_q  <= mode_cont;
      end

      if (go || state_nx == IDLE)  stop_pend <= 1'b0;
      else if (state == CAPT && stop) stop_pend <= 1'b1;

      en_ad       <= wr;
      frame_start <= wr && (scnt == '0);
      frame_done  <= frame_end;
      if (wr) din_ad <= adc_data;

      if (go)           ovf_err <= 1'b0;
      else if (ovf_set) ovf_err <= 1'b1;

      if (go)             frame_cnt <= '0;
      else if (frame_end) frame_cnt <= frame_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ad_frame_ctrl.sv
// Directed self-checking bench for ad_frame_ctrl with NALL=4 (16-sample frames).
module tb_ad_frame_ctrl;

  localparam int WIDTH = 16;
  localparam int NALL  = 4;
  localparam int DW    = 4;
  localparam int GW    = 8;
  localparam int FCW   = 16;

  logic             areset, clk_ad, start, stop, mode_cont, adc_valid, fifo_full;
  logic [DW-1:0]    decim;
  logic [GW-1:0]    gap;
  logic [WIDTH-1:0] adc_data;
  logic             en_ad, frame_start, frame_done, busy, ovf_err;
  logic [WIDTH-1:0] din_ad;
  logic [FCW-1:0]   frame_cnt;

  typedef struct packed {
    logic [WIDTH-1:0] d;
    logic             fs;
    logic             fd;
  } wr_t;

  wr_t              wr_log[$];
  int               n_chk, n_bad;
  logic [WIDTH-1:0] data_ctr, mark;

  ad_frame_ctrl #(
    .width (WIDTH), .NALL (NALL), .DW (DW), .GW (GW), .FCW (FCW)
  ) dut (
    .areset      (areset),
    .clk_ad      (clk_ad),
    .start       (start),
    .stop        (stop),
    .mode_cont   (mode_cont),
    .decim       (decim),
    .gap         (gap),
    .adc_valid   (adc_valid),
    .adc_data    (adc_data),
    .fifo_full   (fifo_full),
    .en_ad       (en_ad),
    .din_ad      (din_ad),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .busy        (busy),
    .ovf_err     (ovf_err),
    .frame_cnt   (frame_cnt)
  );

  initial clk_ad = 1'b0;
  always #5 clk_ad = ~clk_ad;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: sample outputs 1 time unit after the edge, log any write,
  // then present the next ADC sample (a running counter).
  task automatic tick();
    @(posedge clk_ad);
    #1;
    if (en_ad) wr_log.push_back({din_ad, frame_start, frame_done});
    adc_data = data_ctr;
    data_ctr = data_ctr + 1'b1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  // First accepted sample is the one presented right after the start cycle.
  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    mark  = adc_data;
  endtask

  task automatic wait_writes(input int n, input int budget, input string tag);
    int k = 0;
    while (wr_log.size() < n && k < budget) begin
      tick();
      k++;
    end
    check({tag, "_wait"}, 32'(wr_log.size()), 32'(n));
  endtask

  function automatic wr_t at(input int i);
    if (i < wr_log.size()) return wr_log[i];
    return '0;
  endfunction

  // Data 0 never occurs (counter starts at 0x100), so a missing entry fails.
  task automatic check_wr(input string tag, input int i, input logic [WIDTH-1:0] d);
    wr_t w;
    w = at(i);
    check(tag, 32'(w.d), 32'(d));
  endtask

  task automatic check_flags(input string tag, input int i, input logic fs, input logic fd);
    wr_t w;
    w = at(i);
    check(tag, {30'd0, w.fs, w.fd}, {30'd0, fs, fd});
  endtask

  function automatic int count_fs();
    int c = 0;
    foreach (wr_log[i]) c += int'(wr_log[i].fs);
    return c;
  endfunction

  function automatic int count_fd();
    int c = 0;
    foreach (wr_log[i]) c += int'(wr_log[i].fd);
    return c;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk     = 0;
    n_bad     = 0;
    areset    = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
    mode_cont = 1'b0;
    adc_valid = 1'b1;
    fifo_full = 1'b0;
    decim     = '0;
    gap       = '0;
    adc_data  = '0;
    data_ctr  = 16'h0100;

    // Reset state
    repeat (3) @(posedge clk_ad);
    #1;
    check("rst_en_ad", 32'(en_ad), 32'd0);
    check("rst_din_ad", 32'(din_ad), 32'd0);
    check("rst_fs_fd", {30'd0, frame_start, frame_done}, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ovf", 32'(ovf_err), 32'd0);
    check("rst_fcnt", 32'(frame_cnt), 32'd0);
    areset = 1'b1;
    run(2);

    // 1: single shot, decim 0
    do_start();
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_no_early_wr", 32'(en_ad), 32'd0);
    tick();
    check("t1_lat_en", 32'(en_ad), 32'd1);
    check("t1_lat_din", 32'(din_ad), 32'(mark));
    run(25);
    check("t1_nwr", 32'(wr_log.size()), 32'd16);
    for (int i = 0; i < 16; i++) check_wr("t1_data", i, mark + WIDTH'(i));
    check_flags("t1_first", 0, 1'b1, 1'b0);
    check_flags("t1_last", 15, 1'b0, 1'b1);
    check("t1_nfs", 32'(count_fs()), 32'd1);
    check("t1_nfd", 32'(count_fd()), 32'd1);
    check("t1_fcnt", 32'(frame_cnt), 32'd1);
    check("t1_idle", 32'(busy), 32'd0);

    // 2: continuous, decim 2, gap 3; config changed after start has no effect
    wr_log.delete();
    mode_cont = 1'b1;
    decim     = 4'd2;
    gap       = 8'd3;
    do_start();
    decim     = 4'd0;
    gap       = 8'd0;
    mode_cont = 1'b0;
    wait_writes(48, 400, "t2");
    check("t2_fcnt", 32'(frame_cnt), 32'd3);
    check_wr("t2_w1", 1, mark + 16'd3);
    check_wr("t2_w15", 15, mark + 16'd45);
    // 3 gap slots (48, 51, 54) then next frame starts at 57
    check_wr("t2_w16", 16, mark + 16'd57);
    check_flags("t2_f2_start", 16, 1'b1, 1'b0);
    check_wr("t2_w47", 47, mark + 16'd159);
    check_flags("t2_f3_done", 47, 1'b0, 1'b1);
    check("t2_in_gap", 32'(busy), 32'd1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("t2_gap_stop", 32'(busy), 32'd0);
    run(30);
    check("t2_no_more_wr", 32'(wr_log.size()), 32'd48);

    // 3: stop at write 5 of a continuous, gapless frame
    wr_log.delete();
    decim     = '0;
    gap       = '0;
    mode_cont = 1'b1;
    do_start();
    wait_writes(5, 20, "t3");
    stop = 1'b1;
    tick();
    stop = 1'b0;
    run(40);
    check("t3_nwr", 32'(wr_log.size()), 32'd16);
    check_wr("t3_w15", 15, mark + 16'd15);
    check_flags("t3_last", 15, 1'b0, 1'b1);
    check("t3_fcnt", 32'(frame_cnt), 32'd1);
    check("t3_idle", 32'(busy), 32'd0);

    // 4: overflow at write 7 of the second frame, then restart from HALT
    wr_log.delete();
    mode_cont = 1'b1;
    do_start();
    wait_writes(22, 60, "t4");
    fifo_full = 1'b1;
    tick();
    fifo_full = 1'b0;
    run(10);
    check("t4_nwr", 32'(wr_log.size()), 32'd22);
    check("t4_ovf", 32'(ovf_err), 32'd1);
    check("t4_halt_busy", 32'(busy), 32'd0);
    check("t4_fcnt", 32'(frame_cnt), 32'd1);
    wr_log.delete();
    mode_cont = 1'b0;
    do_start();
    check("t4r_ovf_clr", 32'(ovf_err), 32'd0);
    check("t4r_fcnt_clr", 32'(frame_cnt), 32'd0);
    check("t4r_busy", 32'(busy), 32'd1);
    wait_writes(16, 40, "t4r");
    run(5);
    check("t4r_nwr", 32'(wr_log.size()), 32'd16);
    check_wr("t4r_w0", 0, mark);
    check_flags("t4r_first", 0, 1'b1, 1'b0);
    check_flags("t4r_last", 15, 1'b0, 1'b1);
    check("t4r_fcnt", 32'(frame_cnt), 32'd1);

    // 5: start with stop in IDLE does nothing
    wr_log.delete();
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    run(10);
    check("t5_nwr", 32'(wr_log.size()), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);

    // 6: reset at write 9, then a fresh frame
    wr_log.delete();
    do_start();
    wait_writes(9, 20, "t6");
    areset = 1'b0;
    #1;
    check("t6_rst_en", 32'(en_ad), 32'd0);
    check("t6_rst_din", 32'(din_ad), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    run(2);
    areset = 1'b1;
    wr_log.delete();
    run(2);
    do_start();
    wait_writes(16, 40, "t6r");
    run(3);
    check("t6r_nwr", 32'(wr_log.size()), 32'd16);
    check_wr("t6r_w0", 0, mark);
    check_wr("t6r_w15", 15, mark + 16'd15);
    check_flags("t6r_first", 0, 1'b1, 1'b0);
    check_flags("t6r_last", 15, 1'b0, 1'b1);
    check("t6r_fcnt", 32'(frame_cnt), 32'd1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
